// File: rtl/restoring_divider_if.sv
// Request/response bundle between the muldiv execute unit and the restoring divider.
// Signal suffixes are named from the divider's point of view.
interface restoring_divider_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             start_i;
    logic             ready_o;
    logic             done_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;

    modport master (
        output dividend_i, divisor_i, start_i,
        input  ready_o, done_o, quotient_o, remainder_o
    );

    modport slave (
        input  dividend_i, divisor_i, start_i,
        output ready_o, done_o, quotient_o, remainder_o
    );
endinterface

// File: rtl/restoring_divider.sv
// Iterative unsigned radix-2 restoring divider: one quotient bit per cycle,
// quotient and remainder valid on the single-cycle done pulse.
module restoring_divider #(
    parameter int unsigned WIDTH = 32
) (
    input logic              clk_i,
    input logic              reset_n_i,
    restoring_divider_if.slave div_if
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             take;

    // Compare is WIDTH+1 bits; the subtraction only needs WIDTH bits because
    // whenever it is taken the true difference is below 2^WIDTH.
    always_comb begin
        trial = {rem_q, quot_q[WIDTH-1]};
        take  = (trial >= {1'b0, divisor_q});
        diff  = trial[WIDTH-1:0] - divisor_q;
    end

    always_comb begin
        state_d   = state_q;
        divisor_d = divisor_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (div_if.start_i) begin
                    divisor_d = div_if.divisor_i;
                    quot_d    = div_if.dividend_i;
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                rem_d  = take ? diff : trial[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], take};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            divisor_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            divisor_q <= divisor_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
        end
    end

    assign div_if.ready_o     = (state_q == IDLE);
    assign div_if.done_o      = (state_q == DONE);
    assign div_if.quotient_o  = quot_q;
    assign div_if.remainder_o = rem_q;
endmodule

// File: tb/tb_restoring_divider.sv
// Bench for restoring_divider: vector table, handshake corner sequences and a
// random regression, all checked through an expected-result queue.
module tb_restoring_divider;
    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    restoring_divider_if #(.WIDTH(W)) dif ();

    restoring_divider #(.WIDTH(W)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .div_if    (dif.slave)
    );

    res_t sb[$];
    res_t mon_exp;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;
    vec_t vecs[10];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired (got no event, expected one)", name);
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t m;
        if (b == '0) begin
            m.q = '1;
            m.r = a;
        end else begin
            m.q = a / b;
            m.r = a % b;
        end
        return m;
    endfunction

    // Result monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n && dif.done_o) begin
            done_cnt++;
            check_bit("done_single_cycle", prev_done, 1'b0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done pulse expected none");
            end else begin
                mon_exp = sb.pop_front();
                check("quotient", dif.quotient_o, mon_exp.q);
                check("remainder", dif.remainder_o, mon_exp.r);
            end
        end
        prev_done = rst_n && dif.done_o;
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input bit timing);
        int n;
        @(negedge clk);
        dif.dividend_i = a;
        dif.divisor_i  = b;
        dif.start_i    = 1'b1;
        n = 0;
        while (!dif.ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!dif.ready_o) begin
            dif.start_i = 1'b0;
            bound_fail("accept");
            return;
        end
        sb.push_back('{q: eq, r: er});
        @(negedge clk);
        dif.start_i    = 1'b0;
        dif.dividend_i = $urandom;
        dif.divisor_i  = $urandom;
        if (timing) check_bit("ready_low_after_accept", dif.ready_o, 1'b0);
        // n = number of rising edges since the acceptance edge
        n = 0;
        while (!dif.done_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!dif.done_o) begin
            bound_fail("done");
            return;
        end
        if (timing) check("latency_edges", W'(n), W'(W));
        @(negedge clk);
        if (timing) begin
            check_bit("ready_after_done", dif.ready_o, 1'b1);
            check_bit("done_cleared", dif.done_o, 1'b0);
            repeat (3) @(negedge clk);
            check("quotient_hold", dif.quotient_o, eq);
            check("remainder_hold", dif.remainder_o, er);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) bound_fail("drain");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t m;
        logic [W-1:0] a, b, x, y;
        int k, d0;

        vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2};
        vecs[1] = '{a: 32'h0000_1234,  b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'h0000_1234};
        vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0};
        vecs[3] = '{a: 32'hFFFF_FFFF,  b: 32'h8000_0000,  q: 32'd1,          r: 32'h7FFF_FFFF};
        vecs[4] = '{a: 32'd5,          b: 32'd9,          q: 32'd0,          r: 32'd5};
        vecs[5] = '{a: 32'd81,         b: 32'd9,          q: 32'd9,          r: 32'd0};
        vecs[6] = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0};
        vecs[7] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0};
        vecs[8] = '{a: 32'h8000_0000,  b: 32'd3,          q: 32'h2AAA_AAAA,  r: 32'd2};
        vecs[9] = '{a: 32'd1_000_000,  b: 32'd1000,       q: 32'd1000,       r: 32'd0};

        dif.start_i    = 1'b0;
        dif.dividend_i = '0;
        dif.divisor_i  = '0;
        #12;
        check_bit("reset_ready", dif.ready_o, 1'b1);
        check_bit("reset_done", dif.done_o, 1'b0);
        check("reset_quotient", dif.quotient_o, '0);
        check("reset_remainder", dif.remainder_o, '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b1);

        // start held high with operands changing every cycle
        @(negedge clk);
        dif.dividend_i = 32'd100;
        dif.divisor_i  = 32'd7;
        dif.start_i    = 1'b1;
        check_bit("held_first_ready", dif.ready_o, 1'b1);
        sb.push_back('{q: 32'd14, r: 32'd2});
        k = 0;
        x = '0;
        y = '0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            x = $urandom;
            y = $urandom_range(1, 1000);
            dif.dividend_i = x;
            dif.divisor_i  = y;
            if (dif.ready_o) begin
                k = i;
                break;
            end
        end
        if (k == 0) bound_fail("held_second_ready");
        check("held_second_accept_edge", W'(k), W'(W + 2));
        check("held_first_done_seen", W'(sb.size()), W'(0));
        m = model(x, y);
        sb.push_back(m);
        @(negedge clk);
        dif.start_i = 1'b0;
        drain();

        // reset during iteration 10 aborts without a done pulse
        @(negedge clk);
        dif.dividend_i = 32'd1000;
        dif.divisor_i  = 32'd3;
        dif.start_i    = 1'b1;
        sb.push_back('{q: 32'd333, r: 32'd1});
        @(negedge clk);
        dif.start_i = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("abort_ready", dif.ready_o, 1'b1);
        check_bit("abort_done", dif.done_o, 1'b0);
        check("abort_quotient", dif.quotient_o, '0);
        check("abort_remainder", dif.remainder_o, '0);
        sb.delete();
        d0 = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_done", W'(done_cnt), W'(d0));
        do_op(32'd81, 32'd9, 32'd9, 32'd0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = '0;
                1, 2, 3: b = W'($urandom_range(1, 15));
                4:       b = a >> $urandom_range(0, 31);
                5:       b = $urandom | 32'h8000_0000;
                default: b = $urandom;
            endcase
            m = model(a, b);
            do_op(a, b, m.q, m.r, 1'b0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
